// File: rtl/hazard_fwd_unit_p.sv
// Hazard detection and forwarding unit for the 5-stage pipeline: operand forward
// selects, multi-cycle load-use stalls, memory-wait freeze, branch flush, stall counter.
module hazard_fwd_unit_p #(
   parameter int REG_AW     = 4,
   parameter int NUM_SRC    = 3,
   parameter int LOAD_STALL = 1,
   parameter int PERF_W     = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_SRC*REG_AW-1:0]   id_src,
   input  logic [NUM_SRC-1:0]          id_src_valid,
   input  logic [REG_AW-1:0]           ex_rd,
   input  logic [REG_AW-1:0]           mem_rd,
   input  logic [REG_AW-1:0]           wb_rd,
   input  logic                        ex_rf_en,
   input  logic                        mem_rf_en,
   input  logic                        wb_rf_en,
   input  logic                        ex_load,
   input  logic                        mem_wait,
   input  logic                        branch_taken,
   input  logic                        perf_clr,
   output logic [NUM_SRC*2-1:0]        fwd_sel,
   output logic                        nop_insert_n,
   output logic                        ifid_en,
   output logic                        ifid_flush,
   output logic                        pc_en,
   output logic                        pipe_en,
   output logic                        stall_busy,
   output logic [PERF_W-1:0]           stall_cycles
);

   localparam int CW = (LOAD_STALL < 1) ? 1 : $clog2(LOAD_STALL + 1);
   localparam logic [CW-1:0] LOAD_M1 = CW'(LOAD_STALL - 1);
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_STALL = 1'b1;

   if (LOAD_STALL < 1 || LOAD_STALL > 15 || REG_AW < 1 || NUM_SRC < 1 || PERF_W < 2) begin : g_param_err
      $error("hazard_fwd_unit_p: parameter out of range");
   end

   logic [0:0]              r_state;
   logic [0:0]              w_state_nx;
   logic [CW-1:0]           r_cnt;
   logic [CW-1:0]           w_cnt_nx;
   logic [PERF_W-1:0]       r_perf;
   logic [NUM_SRC*2-1:0]    w_fwd;
   logic                    w_hz_any;
   logic                    w_hz;
   logic                    w_bubble;
   logic [REG_AW-1:0]       w_src;

   // Priority EX > MEM > WB; only a stage that writes the RF can supply a value.
   function automatic logic [1:0] fwd_pick(
      input logic              valid,
      input logic [REG_AW-1:0] src,
      input logic [REG_AW-1:0] e_rd, m_rd, w_rd,
      input logic              e_en, m_en, w_en
   );
      logic [1:0] sel;
      if (!valid) begin
         sel = 2'b00;
      end else if (e_en && e_rd == src) begin
         sel = 2'b01;
      end else if (m_en && m_rd == src) begin
         sel = 2'b10;
      end else if (w_en && w_rd == src) begin
         sel = 2'b11;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Per-operand forward selects and load-use match against the EX destination.
   always_comb begin
      w_fwd    = {(NUM_SRC*2){1'b0}};
      w_hz_any = 1'b0;
      w_src    = {REG_AW{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         w_src = id_src[i*REG_AW +: REG_AW];
         w_fwd[i*2 +: 2] = fwd_pick(id_src_valid[i], w_src, ex_rd, mem_rd, wb_rd,
                                    ex_rf_en, mem_rf_en, wb_rf_en);
         if (id_src_valid[i] && w_src == ex_rd) begin
            w_hz_any = 1'b1;
         end else begin
            w_hz_any = w_hz_any;
         end
      end
   end

   assign w_hz     = ex_load & ex_rf_en & w_hz_any;
   assign w_bubble = !mem_wait && !branch_taken && (r_state == ST_STALL || w_hz);

   // Stall sequencing: mem_wait freezes, a taken branch squashes the stalled instruction.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      if (mem_wait) begin
         w_state_nx = r_state;
         w_cnt_nx   = r_cnt;
      end else if (branch_taken) begin
         w_state_nx = ST_IDLE;
         w_cnt_nx   = {CW{1'b0}};
      end else if (r_state == ST_IDLE) begin
         if (w_hz) begin
            w_cnt_nx   = LOAD_M1;
            w_state_nx = (LOAD_M1 != {CW{1'b0}}) ? ST_STALL : ST_IDLE;
         end else begin
            w_cnt_nx   = {CW{1'b0}};
            w_state_nx = ST_IDLE;
         end
      end else begin
         w_cnt_nx   = r_cnt - {{(CW-1){1'b0}}, 1'b1};
         w_state_nx = (r_cnt == {{(CW-1){1'b0}}, 1'b1}) ? ST_IDLE : ST_STALL;
      end
   end

   // Stall state and counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= {CW{1'b0}};
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // Pipeline control; reset forces everything to its inactive value immediately.
   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      pipe_en      = 1'b1;
      nop_insert_n = 1'b1;
      ifid_flush   = 1'b0;
      if (!reset_n) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         pipe_en      = 1'b0;
         nop_insert_n = 1'b0;
      end else if (mem_wait) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
         pipe_en = 1'b0;
      end else if (branch_taken) begin
         ifid_flush   = 1'b1;
         nop_insert_n = 1'b0;
      end else if (w_bubble) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         nop_insert_n = 1'b0;
      end else begin
         pc_en = 1'b1;
      end
   end

   assign fwd_sel    = reset_n ? w_fwd : {(NUM_SRC*2){1'b0}};
   assign stall_busy = reset_n && (r_state == ST_STALL);

   // Saturating count of cycles with the PC held; clear wins over increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_perf <= {PERF_W{1'b0}};
      end else if (perf_clr) begin
         r_perf <= {PERF_W{1'b0}};
      end else if (!pc_en && r_perf != {PERF_W{1'b1}}) begin
         r_perf <= r_perf + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
         r_perf <= r_perf;
      end
   end

   assign stall_cycles = r_perf;

endmodule

// File: tb/tb_hazard_fwd_unit_p.sv
// Directed bench for hazard_fwd_unit_p: instance A (LOAD_STALL=1, PERF_W=16) and
// instance B (LOAD_STALL=3, PERF_W=4) share stimulus and are checked cycle by cycle.
module tb_hazard_fwd_unit_p;

   logic        clk;
   logic        reset_n;
   logic [11:0] id_src;
   logic [2:0]  id_src_valid;
   logic [3:0]  ex_rd, mem_rd, wb_rd;
   logic        ex_rf_en, mem_rf_en, wb_rf_en;
   logic        ex_load, mem_wait, branch_taken, perf_clr;

   logic [5:0]  fwd_a, fwd_b;
   logic        nop_a, nop_b, ifid_a, ifid_b, flush_a, flush_b;
   logic        pc_a, pc_b, pipe_a, pipe_b, busy_a, busy_b;
   logic [15:0] perf_a;
   logic [3:0]  perf_b;

   int checks = 0;
   int errors = 0;

   hazard_fwd_unit_p #(.REG_AW(4), .NUM_SRC(3), .LOAD_STALL(1), .PERF_W(16)) u_a (
      .clk(clk), .reset_n(reset_n), .id_src(id_src), .id_src_valid(id_src_valid),
      .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_rf_en(ex_rf_en), .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en),
      .ex_load(ex_load), .mem_wait(mem_wait), .branch_taken(branch_taken), .perf_clr(perf_clr),
      .fwd_sel(fwd_a), .nop_insert_n(nop_a), .ifid_en(ifid_a), .ifid_flush(flush_a),
      .pc_en(pc_a), .pipe_en(pipe_a), .stall_busy(busy_a), .stall_cycles(perf_a)
   );

   hazard_fwd_unit_p #(.REG_AW(4), .NUM_SRC(3), .LOAD_STALL(3), .PERF_W(4)) u_b (
      .clk(clk), .reset_n(reset_n), .id_src(id_src), .id_src_valid(id_src_valid),
      .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_rf_en(ex_rf_en), .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en),
      .ex_load(ex_load), .mem_wait(mem_wait), .branch_taken(branch_taken), .perf_clr(perf_clr),
      .fwd_sel(fwd_b), .nop_insert_n(nop_b), .ifid_en(ifid_b), .ifid_flush(flush_b),
      .pc_en(pc_b), .pipe_en(pipe_b), .stall_busy(busy_b), .stall_cycles(perf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      id_src = 12'h000; id_src_valid = 3'b000;
      ex_rd = 4'h0; mem_rd = 4'h0; wb_rd = 4'h0;
      ex_rf_en = 1'b0; mem_rf_en = 1'b0; wb_rf_en = 1'b0;
      ex_load = 1'b0; mem_wait = 1'b0; branch_taken = 1'b0; perf_clr = 1'b0;
   endtask

   // Load hazard on operand 1: EX loads r5, ID reads r5.
   task automatic hazard_in();
      idle_in();
      id_src = {4'h0, 4'h5, 4'h0}; id_src_valid = 3'b010;
      ex_rd = 4'h5; ex_rf_en = 1'b1; ex_load = 1'b1;
   endtask

   task automatic next_cyc();
      @(negedge clk);
   endtask

   initial begin
      idle_in();
      reset_n = 1'b0;
      id_src = {4'h0, 4'h0, 4'h3}; id_src_valid = 3'b001; ex_rd = 4'h3; ex_rf_en = 1'b1;
      #2;
      chk("rst_pc", pc_a, 0);     chk("rst_ifid", ifid_a, 0); chk("rst_pipe", pipe_a, 0);
      chk("rst_nop", nop_a, 0);   chk("rst_flush", flush_a, 0); chk("rst_fwd", fwd_a, 0);
      chk("rst_busy", busy_b, 0); chk("rst_perf", perf_a, 0);
      next_cyc();
      reset_n = 1'b1;

      // Forwarding priority on operand 0
      idle_in();
      id_src = {4'h0, 4'h0, 4'h3}; id_src_valid = 3'b001;
      ex_rd = 4'h3; mem_rd = 4'h3; wb_rd = 4'h3;
      ex_rf_en = 1'b1; mem_rf_en = 1'b1; wb_rf_en = 1'b1;
      #2; chk("fwd_ex", fwd_a, 6'b000001); chk("fwd_pc", pc_a, 1); chk("fwd_nop", nop_a, 1);
      ex_rf_en = 1'b0;
      #1; chk("fwd_mem", fwd_a, 6'b000010);
      mem_rf_en = 1'b0;
      #1; chk("fwd_wb", fwd_a, 6'b000011);
      id_src_valid = 3'b000;
      #1; chk("fwd_invalid", fwd_a, 6'b000000);
      // independent operands: op0=r3<-WB, op1=r4<-EX, op2=r5<-MEM
      id_src = {4'h5, 4'h4, 4'h3}; id_src_valid = 3'b111;
      ex_rd = 4'h4; mem_rd = 4'h5; wb_rd = 4'h3;
      ex_rf_en = 1'b1; mem_rf_en = 1'b1; wb_rf_en = 1'b1;
      #1; chk("fwd_indep", fwd_b, 6'b100111);
      // upper index bit differs: no match
      id_src = {4'h0, 4'h0, 4'h3}; id_src_valid = 3'b001;
      ex_rd = 4'hB; mem_rf_en = 1'b0; wb_rf_en = 1'b0;
      #1; chk("fwd_fullwidth", fwd_a, 6'b000000);
      next_cyc();

      // Load-use: A stalls 1 cycle, B stalls 3
      hazard_in();
      #2; chk("lu1_pc", pc_a, 0); chk("lu1_ifid", ifid_a, 0); chk("lu1_nop", nop_a, 0);
      chk("lu1_pipe", pipe_a, 1); chk("lu1_busyA", busy_a, 0); chk("lu1_pcB", pc_b, 0);
      chk("lu1_busyB", busy_b, 0);
      next_cyc();
      idle_in();
      id_src = {4'h0, 4'h5, 4'h0}; id_src_valid = 3'b010; mem_rd = 4'h5; mem_rf_en = 1'b1;
      #2; chk("lu2_pcA", pc_a, 1); chk("lu2_ifidA", ifid_a, 1); chk("lu2_nopA", nop_a, 1);
      chk("lu2_fwdA", fwd_a, 6'b001000);
      chk("lu2_pcB", pc_b, 0); chk("lu2_nopB", nop_b, 0); chk("lu2_pipeB", pipe_b, 1);
      chk("lu2_busyB", busy_b, 1);
      next_cyc();
      idle_in();
      #2; chk("lu3_pcB", pc_b, 0); chk("lu3_busyB", busy_b, 1);
      next_cyc();
      #2; chk("lu4_pcB", pc_b, 1); chk("lu4_busyB", busy_b, 0);
      chk("lu4_perfB", perf_b, 3); chk("lu4_perfA", perf_a, 1);

      // mem_wait in the middle of B's stall
      perf_clr = 1'b1;
      next_cyc();
      perf_clr = 1'b0;
      #2; chk("clr_perfB", perf_b, 0); chk("clr_perfA", perf_a, 0);
      next_cyc();
      hazard_in();
      #2; chk("mw1_pcB", pc_b, 0);
      next_cyc();
      idle_in();
      #2; chk("mw2_busyB", busy_b, 1);
      next_cyc();
      for (int k = 0; k < 2; k++) begin
         idle_in();
         mem_wait = 1'b1;
         id_src = {4'h0, 4'h0, 4'h3}; id_src_valid = 3'b001; wb_rd = 4'h3; wb_rf_en = 1'b1;
         #2; chk("mw_pipeB", pipe_b, 0); chk("mw_pcB", pc_b, 0); chk("mw_nopB", nop_b, 1);
         chk("mw_ifidB", ifid_b, 0); chk("mw_flushB", flush_b, 0); chk("mw_busyB", busy_b, 1);
         chk("mw_fwdB", fwd_b, 6'b000011);
         next_cyc();
      end
      idle_in();
      #2; chk("mw5_pcB", pc_b, 0); chk("mw5_nopB", nop_b, 0); chk("mw5_pipeB", pipe_b, 1);
      next_cyc();
      #2; chk("mw6_pcB", pc_b, 1); chk("mw6_perfB", perf_b, 5); chk("mw6_perfA", perf_a, 3);

      // Taken branch on stall cycle 2 cancels the stall
      perf_clr = 1'b1;
      next_cyc();
      hazard_in();
      #2; chk("br1_pcB", pc_b, 0);
      next_cyc();
      idle_in();
      branch_taken = 1'b1;
      #2; chk("br2_flushB", flush_b, 1); chk("br2_pcB", pc_b, 1); chk("br2_ifidB", ifid_b, 1);
      chk("br2_nopB", nop_b, 0); chk("br2_pipeB", pipe_b, 1);
      next_cyc();
      idle_in();
      #2; chk("br3_busyB", busy_b, 0); chk("br3_pcB", pc_b, 1); chk("br3_perfB", perf_b, 1);
      next_cyc();

      // Reset asserted in the middle of a stall
      hazard_in();
      next_cyc();
      idle_in();
      #2; chk("rs_busy_pre", busy_b, 1); chk("rs_pipe_pre", pipe_b, 1);
      reset_n = 1'b0;
      #1; chk("rs_pipe", pipe_b, 0); chk("rs_busy", busy_b, 0); chk("rs_pc", pc_b, 0);
      chk("rs_perf", perf_b, 0);
      next_cyc();
      reset_n = 1'b1;
      #2; chk("rs_after_pc", pc_b, 1); chk("rs_after_busy", busy_b, 0); chk("rs_after_perf", perf_b, 0);
      next_cyc();

      // Saturation of the 4-bit counter
      idle_in();
      mem_wait = 1'b1;
      for (int k = 0; k < 20; k++) next_cyc();
      #2; chk("sat_perfB", perf_b, 15); chk("sat_perfA", perf_a, 20);
      perf_clr = 1'b1;
      next_cyc();
      perf_clr = 1'b0;
      #2; chk("satclr_perfB", perf_b, 0); chk("satclr_pcB", pc_b, 0);
      next_cyc();
      mem_wait = 1'b0;
      #2; chk("satinc_perfB", perf_b, 1);
      next_cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
